sad_block_accum: RTL

- Streaming sum-of-absolute-differences (SAD) engine for the hexagonal-search motion estimator.
- Consumes LANES current/reference pixel pairs per beat over one candidate block and computes per-lane absolute differences.
- Accumulates them into a single SAD value and presents it to the search controller with a valid/ready handshake.
- Sits between the pixel fetch unit (upstream) and the hexagon min-compare logic (downstream).

---
 rtl/sad_pkg.sv | 35 +++
 rtl/sad_absdiff.sv | 39 +++
 rtl/sad_block_accum.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sad_pkg.sv
// Shared definitions for the SAD block accumulator.
// Holds default pixel geometry, result/lane-sum width helpers, the
// controller state encoding and the lane slicing helper.
package sad_pkg;

  localparam int unsigned PIX_W_DEF      = 8;
  localparam int unsigned LANES_DEF      = 4;
  localparam int unsigned BLK_PIXELS_DEF = 256;

  // Width that holds the SAD of a full block without overflow.
  function automatic int unsigned sad_width(input int unsigned pix_w,
                                            input int unsigned blk_pixels);
    return pix_w + $clog2(blk_pixels);
  endfunction

  // Width that holds the sum of one beat's lane differences.
  function automatic int unsigned lane_sum_width(input int unsigned pix_w,
                                                 input int unsigned lanes);
    return pix_w + ((lanes > 1) ? $clog2(lanes) : 0);
  endfunction

  // LSB position of a lane inside a packed pixel beat.
  function automatic int unsigned lane_lo(input int unsigned lane,
                                          input int unsigned pix_w);
    return lane * pix_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } sad_state_e;

endpackage

// File: rtl/sad_absdiff.sv
// Registered absolute difference of one pixel pair.
// Ports: clk, rst_n (async active-low), i_en (capture enable),
//        i_a / i_b (pixels), o_diff (registered |i_a - i_b|).
module sad_absdiff
  import sad_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [PIX_W-1:0] i_a,
  input  logic [PIX_W-1:0] i_b,
  output logic [PIX_W-1:0] o_diff
);

  logic [PIX_W:0]   w_sub;
  logic             w_borrow;
  logic [PIX_W-1:0] w_abs;
  logic [PIX_W-1:0] r_diff;

  // Subtract once, and pick the reversed subtraction when it borrows.
  always_comb begin
    w_sub    = {1'b0, i_a} - {1'b0, i_b};
    w_borrow = w_sub[PIX_W];
    w_abs    = w_borrow ? (i_b - i_a) : w_sub[PIX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff <= '0;
    end else if (i_en) begin
      r_diff <= w_abs;
    end
  end

  assign o_diff = r_diff;

endmodule

// File: rtl/sad_block_accum.sv
// Streaming sum-of-absolute-differences over one candidate block.
// Ports: clk, rst_n (async active-low), start (open a new block),
//        in_valid/in_ready + cur_pix/ref_pix (LANES packed pixel pairs),
//        sad/out_valid/out_ready (result handshake), busy (not idle).
// Build option SAD_EARLY_TERM_EN adds sad_thresh (sampled at start) and
// sad_abort: once the running sum exceeds the threshold, accumulation
// stops and the result reads all-ones with sad_abort set.
module sad_block_accum
  import sad_pkg::*;
#(
  parameter int unsigned PIX_W      = PIX_W_DEF,
  parameter int unsigned LANES      = LANES_DEF,
  parameter int unsigned BLK_PIXELS = BLK_PIXELS_DEF,
  parameter int unsigned SAD_W      = sad_width(PIX_W, BLK_PIXELS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*PIX_W-1:0] cur_pix,
  input  logic [LANES*PIX_W-1:0] ref_pix,
  output logic [SAD_W-1:0]       sad,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
`ifdef SAD_EARLY_TERM_EN
  ,
  input  logic [SAD_W-1:0]       sad_thresh,
  output logic                   sad_abort
`endif
);

  localparam int unsigned BEATS  = BLK_PIXELS / LANES;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LSUM_W = lane_sum_width(PIX_W, LANES);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  sad_state_e        r_state;
  sad_state_e        w_state_nxt;
  logic              w_clear;
  logic              w_accept;
  logic              w_load;
  logic              w_stop;
  logic [SAD_W-1:0]  w_result;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_v1;
  logic [SAD_W-1:0]  r_acc;
  logic [SAD_W-1:0]  r_sad;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  logic [PIX_W-1:0]  w_diff [LANES];
  logic [LSUM_W-1:0] w_lane_sum;

  // Stage 1: one registered absolute difference per lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sad_absdiff #(
      .PIX_W (PIX_W)
    ) u_absdiff (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_accept),
      .i_a    (cur_pix[lane_lo(g, PIX_W) +: PIX_W]),
      .i_b    (ref_pix[lane_lo(g, PIX_W) +: PIX_W]),
      .o_diff (w_diff[g])
    );
  end

  // Stage 2 adder tree input: sum of this beat's lane differences.
  always_comb begin
    w_lane_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_lane_sum = w_lane_sum + LSUM_W'(w_diff[i]);
    end
  end

  // Next-state and control strobes. A start during ACCUM restarts the
  // block and drops any beat offered in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (start) begin
          w_clear = 1'b1;
        end else if (in_valid) begin
          w_accept = 1'b1;
          if (r_cnt == LAST_BEAT) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Final beat's differences are added once stage 1 is empty.
        if (!r_v1) begin
          w_load      = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and state-decoded outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_ACCUM);
      r_out_valid <= (w_state_nxt == ST_HOLD);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Beat counter, stage-1 valid, accumulator and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_v1  <= 1'b0;
      r_acc <= '0;
      r_sad <= '0;
    end else begin
      if (w_clear) begin
        r_cnt <= '0;
        r_v1  <= 1'b0;
        r_acc <= '0;
      end else begin
        r_v1 <= w_accept;
        if (w_accept) r_cnt <= (r_cnt == LAST_BEAT) ? '0 : r_cnt + CNT_W'(1);
        if (r_v1 && !w_stop) r_acc <= r_acc + SAD_W'(w_lane_sum);
      end
      if (w_load) r_sad <= w_result;
    end
  end

`ifdef SAD_EARLY_TERM_EN
  logic [SAD_W-1:0] r_thresh;
  logic             r_abort;
  logic             r_sad_abort;

  // Abort as soon as the running sum passes the threshold; beats keep
  // flowing so the stream stays aligned, but nothing more is added.
  assign w_stop   = r_abort | (r_acc > r_thresh);
  assign w_result = w_stop ? '1 : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thresh    <= '0;
      r_abort     <= 1'b0;
      r_sad_abort <= 1'b0;
    end else if (w_clear) begin
      r_thresh    <= sad_thresh;
      r_abort     <= 1'b0;
      r_sad_abort <= 1'b0;
    end else begin
      r_abort <= w_stop;
      if (w_load) r_sad_abort <= w_stop;
    end
  end

  assign sad_abort = r_sad_abort;
`else
  assign w_stop   = 1'b0;
  assign w_result = r_acc;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sad       = r_sad;

endmodule
